ring_shift_collector: RTL and testbench
=======================================

// Module: ring_shift_collector
// PURPOSE
//  Deserializer paired with the input-side ring shift serializer: collects N-bit chunks (LSB chunk first)
//  and reassembles them into S-bit words. Sits on the systolic array output/result path, feeding
//  result memory. Valid/ready handshake on both sides, one-word output buffer, one chunk per clock.
// PARAMETERS
//  S       8   assembled word width in bits; S % N == 0 required (elaboration error otherwise)
//  N       2   chunk width in bits
//  CHUNKS  S/N derived localparam: chunks per word; counter width $clog2(CHUNKS), min 1
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   reset, asynchronous, active-high
//  clear       in   1   synchronous flush of partial word and output buffer
//  in_valid    in   1   chunk present on in
//  in          in   N   chunk data
//  in_ready    out  1   chunk accepted when in_valid && in_ready (combinational)
//  word_out    out  S   assembled word (registered)
//  word_valid  out  1   word_out holds an unconsumed word
//  word_ready  in   1   downstream takes word when word_valid && word_ready
//  busy        out  1   cnt != 0 || word_valid
// BEHAVIOUR
//  - Reset (async, rst=1): cnt=0, assembly reg=0, word_out=0, word_valid=0; hence busy=0, in_ready=1.
//  - Chunk k of a word (k=0..CHUNKS-1) lands in bits [k*N +: N]; chunk 0 = LSBs (mirror of serializer).
//  - States implied by cnt: FILL (cnt<CHUNKS-1, in_ready=1 always), LAST (cnt==CHUNKS-1).
//  - in_ready = !(cnt==CHUNKS-1 && word_valid && !word_ready); only the final chunk can stall.
//  - Accept non-final chunk: assembly[k] <= in, cnt <= cnt+1. in_valid=0 gaps hold state, no timeout.
//  - Accept final chunk: word_out <= {in, assembly[S-N-1:0]}, word_valid <= 1, cnt <= 0, assembly <= 0.
//    Latency: word_valid high the cycle after the final chunk is accepted.
//  - Output consumed (word_valid && word_ready) with no final chunk same cycle: word_valid <= 0;
//    word_out holds last value.
//  - Consume and final-chunk accept in same cycle: new word loads, word_valid stays 1 (full rate:
//    one word every CHUNKS cycles, no bubble).
//  - CHUNKS==1: every accepted chunk is a final chunk; word_out = in.
//  - word_out/word_valid stable while word_valid && !word_ready.
//  - clear=1: cnt=0, assembly=0, word_valid=0 next cycle; overrides any same-cycle accept/consume;
//    in_ready still computed normally but accepted data is discarded.
//  - rst mid-word or with pending word: everything discarded immediately, no partial output.
// CONFIGURATION
//  WORD_COUNT_EN defined: extra output word_cnt [15:0]; +1 on each final-chunk accept, wraps at
//    16'hFFFF->0; cleared by rst and clear; clear wins over same-cycle increment.
//  WORD_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (S=8, N=2 unless stated)
//  1 Chunks 01,10,11,00 on 4 consecutive cycles, word_ready=1 -> word_out=8'h39, word_valid 1 cycle after 4th.
//  2 Two back-to-back words (0x39 then 0xC6), word_ready=1 -> word_valid stays high, two words, no gap.
//  3 Word 0x39 pending, word_ready=0, next 3 chunks accepted, 4th sees in_ready=0 until word_ready=1,
//    then 0xC6 delivered; 0x39 never corrupted.
//  4 2 chunks then clear=1 -> busy=0 next cycle; next 4 chunks yield clean word, no stale bits.
//  5 rst asserted asynchronously mid-word and with word pending -> outputs zero without clock edge.
//  6 in_valid toggling 1/0 with random gaps over 100 random words -> scoreboard match; with
//    WORD_COUNT_EN, word_cnt==100.

Source files
------------

// File: rtl/ring_shift_collector.sv
// rtl/ring_shift_collector.sv - reassembles N-bit chunks (LSB chunk first) into S-bit words.
// Optional WORD_COUNT_EN adds a 16-bit count of completed words on word_cnt.
module ring_shift_collector #(
    parameter int S = 8,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [N-1:0] in,
    output logic         in_ready,
    output logic [S-1:0] word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         busy
`ifdef WORD_COUNT_EN
    ,
    output logic [15:0]  word_cnt
`endif
);

    localparam int CHUNKS = S / N;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (S % N != 0) begin : g_bad_width
        $error("ring_shift_collector: S must be a multiple of N");
    end

    logic [CW-1:0] cnt;
    logic [S-1:0]  assembly;
    logic [S-1:0]  asm_merged;
    logic          last;
    logic          accept;
    logic          consume;

    assign last     = (cnt == CW'(CHUNKS - 1));
    // Only the final chunk needs the output buffer, so only it can stall.
    assign in_ready = !(last && word_valid && !word_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = word_valid && word_ready;
    assign busy     = (cnt != '0) || word_valid;

    always_comb begin
        asm_merged = assembly;
        asm_merged[N*int'(cnt) +: N] = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            assembly   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            assembly   <= '0;
            word_valid <= 1'b0;
        end else begin
            if (accept && last) begin
                word_out   <= asm_merged;
                word_valid <= 1'b1;
                cnt        <= '0;
                assembly   <= '0;
            end else begin
                if (accept) begin
                    assembly <= asm_merged;
                    cnt      <= cnt + 1'b1;
                end
                if (consume) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

`ifdef WORD_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (clear) begin
            word_cnt <= '0;
        end else if (accept && last) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_shift_collector.sv
// tb/tb_ring_shift_collector.sv - self-checking bench for ring_shift_collector (S=8, N=2).
module tb_ring_shift_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [1:0] in_d;
    logic       in_ready;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       busy;
`ifdef WORD_COUNT_EN
    logic [15:0] word_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_shift_collector #(.S(8), .N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in_d),
        .in_ready  (in_ready),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy)
`ifdef WORD_COUNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       wr;
        logic       clr;
        logic       er;
        logic       ewv;
        logic [7:0] ewo;
        logic       eb;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_chunk(input logic [1:0] d);
        in_valid = 1'b1;
        in_d     = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] cur_word;
    logic [7:0] got;
    int         chunk_idx;
    int         words_sent;
    int         words_recv;
    int         cycles;
    logic       acc;
    logic       con;

    initial begin
        // v, d, wr, clr | in_ready, word_valid, word_out, busy (after edge)
        tbl[0]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1};
        tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h39, 1'b1};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h39, 1'b1};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC6, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b0};
        tbl[11] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b1};
        tbl[12] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b1};
        tbl[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC6, 1'b0};
        tbl[14] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b1};
        tbl[15] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b1};
        tbl[16] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC6, 1'b1};
        tbl[17] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[19] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[20] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_d = 2'd0; word_ready = 1'b0;
        #12;
        chk("reset word_valid", 32'(word_valid), 32'd0);
        chk("reset word_out", 32'(word_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid   = tbl[i].v;
            in_d       = tbl[i].d;
            word_ready = tbl[i].wr;
            clear      = tbl[i].clr;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d word_valid", i), 32'(word_valid), 32'(tbl[i].ewv));
            chk($sformatf("v%0d word_out", i), 32'(word_out), 32'(tbl[i].ewo));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].eb));
        end
        clear = 1'b0;
`ifdef WORD_COUNT_EN
        chk("word_cnt after clear", 32'(word_cnt), 32'd0);
`endif

        // Asynchronous reset with a word pending and a partial word in flight.
        word_ready = 1'b0;
        send_chunk(2'd1); send_chunk(2'd2); send_chunk(2'd3); send_chunk(2'd0);
        chk("pre-rst pending word", 32'(word_out), 32'h39);
        send_chunk(2'd3); send_chunk(2'd3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst word_valid", 32'(word_valid), 32'd0);
        chk("async rst word_out", 32'(word_out), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random gaps and backpressure over 100 words against a scoreboard.
        chunk_idx = 0; words_sent = 0; words_recv = 0; cycles = 0;
        cur_word = 8'($urandom);
        while (words_recv < 100 && cycles < 5000) begin
            in_valid   = (words_sent < 100) && ($urandom_range(0, 2) != 0);
            in_d       = cur_word[2*chunk_idx +: 2];
            word_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            con = word_valid && word_ready;
            got = word_out;
            @(posedge clk);
            #1;
            cycles++;
            if (con) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("rand word %0d", words_recv), 32'(got), 32'(exp_q.pop_front()));
                end
                words_recv++;
            end
            if (acc) begin
                chunk_idx++;
                if (chunk_idx == 4) begin
                    exp_q.push_back(cur_word);
                    words_sent++;
                    chunk_idx = 0;
                    cur_word  = 8'($urandom);
                end
            end
        end
        in_valid = 1'b0;
        word_ready = 1'b0;
        chk("rand words received", 32'(words_recv), 32'd100);
`ifdef WORD_COUNT_EN
        chk("word_cnt after random", 32'(word_cnt), 32'd100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
